fifo_flags: RTL and testbench

FIFO_FLAGS -- requirements
Module: fifo_flags

---
 rtl/fifo_flags.sv | 137 +++++++++++++
 tb/tb_fifo_flags.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_flags.sv
// Single-clock synchronous FIFO with registered status flags.
// Occupancy and every flag are computed from the post-edge occupancy and
// registered, so they all change on the same edge as the data path.
// OVERFLOW and UNDERFLOW are sticky until reset or CLEAR_N.
module fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int AF_LEVEL   = DEPTH - 4,
  parameter int AE_LEVEL   = 4
) (
  input  logic                   CLOCK,
  input  logic                   RESET_N,
  input  logic                   CLEAR_N,
  input  logic [DATA_WIDTH-1:0]  DATA_IN,
  input  logic                   WRITE,
  input  logic                   READ,
  output logic [DATA_WIDTH-1:0]  DATA_OUT,
  output logic                   F_FULL_N,
  output logic                   F_EMPTY_N,
  output logic                   F_AFULL_N,
  output logic                   F_AEMPTY_N,
  output logic [$clog2(DEPTH):0] USE_DW,
  output logic                   OVERFLOW,
  output logic                   UNDERFLOW
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      use_dw_q, use_dw_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  full_n_q, full_n_d;
  logic                  empty_n_q, empty_n_d;
  logic                  afull_n_q, afull_n_d;
  logic                  aempty_n_q, aempty_n_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic rd_acc;
  logic wr_acc;

  // A read needs a non-empty FIFO; a write into a full FIFO is still taken
  // when a read frees a slot on the same edge. A flush cycle takes neither.
  assign rd_acc = CLEAR_N && READ && empty_n_q;
  assign wr_acc = CLEAR_N && WRITE && (full_n_q || rd_acc);

  // Next-state for pointers, occupancy, read data and sticky error flags.
  // NOTE: combinational blocks use blocking '=' with every output defaulted
  // first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    use_dw_d    = use_dw_q;
    data_out_d  = data_out_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (!CLEAR_N) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      use_dw_d    = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        data_out_d = mem[rd_ptr_q];
      end
      if (wr_acc && !rd_acc)      use_dw_d = use_dw_q + CNT_W'(1);
      else if (rd_acc && !wr_acc) use_dw_d = use_dw_q - CNT_W'(1);
      if (WRITE && !full_n_q && !rd_acc) overflow_d  = 1'b1;
      if (READ && !empty_n_q)            underflow_d = 1'b1;
    end
  end

  // Flags are decoded from the next occupancy so they land with USE_DW.
  always_comb begin
    full_n_d   = (use_dw_d != DEPTH_C);
    empty_n_d  = (use_dw_d != '0);
    afull_n_d  = (use_dw_d < AF_C);
    aempty_n_d = (use_dw_d > AE_C);
  end

  // Control and status registers with synchronous active-low reset.
  // NOTE: sequential blocks use non-blocking '<=' so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      use_dw_q    <= '0;
      data_out_q  <= '0;
      full_n_q    <= 1'b1;
      empty_n_q   <= 1'b0;
      afull_n_q   <= 1'b1;
      aempty_n_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      use_dw_q    <= use_dw_d;
      data_out_q  <= data_out_d;
      full_n_q    <= full_n_d;
      empty_n_q   <= empty_n_d;
      afull_n_q   <= afull_n_d;
      aempty_n_q  <= aempty_n_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage write port.
  // NOTE: the array is deliberately not reset; zeroed pointers make stale
  // words unreachable, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge CLOCK) begin
    if (RESET_N && wr_acc) mem[wr_ptr_q] <= DATA_IN;
  end

  assign DATA_OUT   = data_out_q;
  assign F_FULL_N   = full_n_q;
  assign F_EMPTY_N  = empty_n_q;
  assign F_AFULL_N  = afull_n_q;
  assign F_AEMPTY_N = aempty_n_q;
  assign USE_DW     = use_dw_q;
  assign OVERFLOW   = overflow_q;
  assign UNDERFLOW  = underflow_q;

endmodule

// File: tb/tb_fifo_flags.sv
// Self-checking bench for fifo_flags: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_fifo_flags;

  localparam int DW    = 8;
  localparam int DEPTH = 32;
  localparam int AF    = DEPTH - 4;
  localparam int AE    = 4;

  logic          CLOCK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          CLEAR_N = 1'b1;
  logic [DW-1:0] DATA_IN = '0;
  logic          WRITE = 1'b0;
  logic          READ = 1'b0;
  logic [DW-1:0] DATA_OUT;
  logic          F_FULL_N, F_EMPTY_N, F_AFULL_N, F_AEMPTY_N;
  logic [5:0]    USE_DW;
  logic          OVERFLOW, UNDERFLOW;

  fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .CLEAR_N(CLEAR_N), .DATA_IN(DATA_IN),
    .WRITE(WRITE), .READ(READ), .DATA_OUT(DATA_OUT), .F_FULL_N(F_FULL_N),
    .F_EMPTY_N(F_EMPTY_N), .F_AFULL_N(F_AFULL_N), .F_AEMPTY_N(F_AEMPTY_N),
    .USE_DW(USE_DW), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
  );

  always #5 CLOCK = ~CLOCK;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_step = 0;

  // Reference model: contents as a queue, plus output register and sticky flags.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_dout = '0;
  bit            m_ovf = 1'b0;
  bit            m_udf = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    int sz = m_q.size();
    check($sformatf("s%0d use_dw", n_step),   64'(USE_DW),     64'(sz));
    check($sformatf("s%0d data_out", n_step), 64'(DATA_OUT),   64'(m_dout));
    check($sformatf("s%0d full_n", n_step),   64'(F_FULL_N),   64'(sz != DEPTH));
    check($sformatf("s%0d empty_n", n_step),  64'(F_EMPTY_N),  64'(sz != 0));
    check($sformatf("s%0d afull_n", n_step),  64'(F_AFULL_N),  64'(sz < AF));
    check($sformatf("s%0d aempty_n", n_step), 64'(F_AEMPTY_N), 64'(sz > AE));
    check($sformatf("s%0d overflow", n_step), 64'(OVERFLOW),   64'(m_ovf));
    check($sformatf("s%0d underflow", n_step),64'(UNDERFLOW),  64'(m_udf));
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare.
  task automatic step(input bit wr, input bit rd, input logic [DW-1:0] din,
                      input bit clr_n = 1'b1, input bit rst_n = 1'b1);
    bit was_empty, was_full, do_rd, do_wr;
    WRITE = wr; READ = rd; DATA_IN = din; CLEAR_N = clr_n; RESET_N = rst_n;
    @(posedge CLOCK);
    #1;
    n_step++;
    if (!rst_n) begin
      m_q.delete(); m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
    end else if (!clr_n) begin
      m_q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      was_empty = (m_q.size() == 0);
      was_full  = (m_q.size() == DEPTH);
      do_rd = rd && !was_empty;
      do_wr = wr && (!was_full || do_rd);
      if (rd && was_empty) m_udf = 1'b1;
      if (wr && was_full && !do_rd) m_ovf = 1'b1;
      if (do_rd) m_dout = m_q.pop_front();
      if (do_wr) m_q.push_back(din);
    end
    check_model();
  endtask

  initial begin
    // Reset state
    step(0, 0, '0, 1, 0);
    check("rst data_out", 64'(DATA_OUT), 64'h0);
    check("rst empty_n",  64'(F_EMPTY_N), 64'h0);
    check("rst aempty_n", 64'(F_AEMPTY_N), 64'h0);
    check("rst full_n",   64'(F_FULL_N), 64'h1);
    check("rst afull_n",  64'(F_AFULL_N), 64'h1);

    // Single write then read
    step(1, 0, 8'h01);
    check("one use_dw", 64'(USE_DW), 64'd1);
    check("one empty_n", 64'(F_EMPTY_N), 64'h1);
    step(0, 1, '0);
    check("one rd use_dw", 64'(USE_DW), 64'd0);
    check("one rd data", 64'(DATA_OUT), 64'h01);
    check("one rd empty_n", 64'(F_EMPTY_N), 64'h0);

    // Fill, overflow, drain
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, DW'(i));
      check($sformatf("fill%0d afull_n", i), 64'(F_AFULL_N), 64'(i + 1 < 28));
      check($sformatf("fill%0d full_n", i),  64'(F_FULL_N),  64'(i + 1 < 32));
    end
    step(1, 0, 8'hAA);
    check("ovf flag", 64'(OVERFLOW), 64'h1);
    check("ovf use_dw", 64'(USE_DW), 64'd32);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, '0);
      check($sformatf("drain%0d data", i),     64'(DATA_OUT),   64'(i));
      check($sformatf("drain%0d aempty_n", i), 64'(F_AEMPTY_N), 64'(31 - i > 4));
      check($sformatf("drain%0d empty_n", i),  64'(F_EMPTY_N),  64'(31 - i != 0));
    end
    check("ovf sticky", 64'(OVERFLOW), 64'h1);

    // Read+write while empty
    step(0, 0, '0, 0);
    step(1, 1, 8'h5C);
    check("rw empty udf", 64'(UNDERFLOW), 64'h1);
    check("rw empty use_dw", 64'(USE_DW), 64'd1);
    step(0, 1, '0);
    check("rw empty data", 64'(DATA_OUT), 64'h5C);

    // Read+write while full
    step(0, 0, '0, 0);
    for (int i = 0; i < DEPTH; i++) step(1, 0, DW'(8'h80 + i));
    step(1, 1, 8'h77);
    check("rw full use_dw", 64'(USE_DW), 64'd32);
    check("rw full ovf", 64'(OVERFLOW), 64'h0);
    check("rw full data", 64'(DATA_OUT), 64'h80);
    for (int i = 0; i < DEPTH; i++) step(0, 1, '0);
    check("rw full last", 64'(DATA_OUT), 64'h77);

    // Pointer wrap
    step(0, 0, '0, 0);
    for (int i = 0; i < 16; i++) step(1, 0, DW'(i));
    for (int i = 0; i < 16; i++) begin
      step(0, 1, '0);
      check($sformatf("wrapA%0d", i), 64'(DATA_OUT), 64'(i));
    end
    for (int i = 0; i < 24; i++) step(1, 0, DW'(8'h40 + i));
    for (int i = 0; i < 24; i++) begin
      step(0, 1, '0);
      check($sformatf("wrapB%0d", i), 64'(DATA_OUT), 64'(8'h40 + i));
    end
    check("wrap use_dw", 64'(USE_DW), 64'd0);

    // Clear and reset with 10 words held and OVERFLOW set
    for (int pass = 0; pass < 2; pass++) begin
      step(0, 0, '0, 0);
      for (int i = 0; i < DEPTH; i++) step(1, 0, DW'(i));
      step(1, 0, 8'hEE);
      for (int i = 0; i < 22; i++) step(0, 1, '0);
      check($sformatf("p%0d ten", pass), 64'(USE_DW), 64'd10);
      if (pass == 0) begin
        step(1, 0, 8'h99, 0, 1);
        check("clr data kept", 64'(DATA_OUT), 64'd21);
      end else begin
        step(1, 0, 8'h99, 1, 0);
        check("rst data zero", 64'(DATA_OUT), 64'd0);
      end
      check($sformatf("p%0d use_dw", pass), 64'(USE_DW), 64'd0);
      check($sformatf("p%0d ovf", pass), 64'(OVERFLOW), 64'h0);
      check($sformatf("p%0d empty_n", pass), 64'(F_EMPTY_N), 64'h0);
    end

    // Randomized traffic with varying read/write bias
    for (int blk = 0; blk < 15; blk++) begin
      int p_wr = $urandom_range(15, 85);
      int p_rd = $urandom_range(15, 85);
      for (int c = 0; c < 200; c++) begin
        bit wr  = ($urandom_range(0, 99) < p_wr);
        bit rd  = ($urandom_range(0, 99) < p_rd);
        bit clr = ($urandom_range(0, 99) != 0);
        bit rst = ($urandom_range(0, 399) != 0);
        step(wr, rd, DW'($urandom), clr, rst);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
